parking_ctrl_multi: RTL and testbench

Parametrised multi-slot parking controller for the parking-system design family. It runs the entry-gate password sequence and tracks lot occupancy against a configurable capacity. It refuses entry when the lot is full and locks out the keypad after repeated wrong passwords. It sits between the board-level switch/key inputs and the LED and seven-segment display drivers, which consume its status outputs.

---
 rtl/parking_ctrl_multi.sv | 163 ++++++++++++++++
 tb/tb_parking_ctrl_multi.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_ctrl_multi.sv
// Multi-slot parking controller: entry-gate password FSM with lockout, plus an
// occupancy counter driven by entries and exit-sensor rising edges.
module parking_ctrl_multi #(
    parameter int unsigned       CAPACITY    = 8,
    parameter int unsigned       PASS_W      = 4,
    parameter logic [PASS_W-1:0] PASSWORD    = 4'b1011,
    parameter int unsigned       MAX_TRIES   = 3,
    parameter int unsigned       WAIT_CYCLES = 500,
    parameter int unsigned       OPEN_CYCLES = 200,
    parameter int unsigned       LOCK_CYCLES = 1000
) (
    input  logic                               CLOCK_50,
    input  logic                               RESET,
    input  logic                               entry_sensor,
    input  logic                               exit_sensor,
    input  logic [PASS_W-1:0]                  pass_in,
    input  logic                               pass_submit,
    output logic                               gate_open,
    output logic                               alarm,
    output logic                               lot_full,
    output logic [$clog2(CAPACITY+1)-1:0]      occupancy,
    output logic [$clog2(CAPACITY+1)-1:0]      free_slots,
    output logic [2:0]                         state_code
);

    localparam int unsigned OccW   = $clog2(CAPACITY + 1);
    localparam int unsigned TMax01 = (WAIT_CYCLES > OPEN_CYCLES) ? WAIT_CYCLES : OPEN_CYCLES;
    localparam int unsigned TMax   = (TMax01 > LOCK_CYCLES) ? TMax01 : LOCK_CYCLES;
    localparam int unsigned TimerW = $clog2(TMax + 1);

    localparam logic [TimerW-1:0] WaitLd   = TimerW'(WAIT_CYCLES);
    localparam logic [TimerW-1:0] OpenLd   = TimerW'(OPEN_CYCLES);
    localparam logic [TimerW-1:0] LockLd   = TimerW'(LOCK_CYCLES);
    localparam logic [TimerW-1:0] TimerOne = TimerW'(1);
    localparam logic [OccW-1:0]   CapVal   = OccW'(CAPACITY);
    localparam logic [3:0]        MaxTries = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWaitPass  = 3'd1,
        StWrongPass = 3'd2,
        StGateOpen  = 3'd3,
        StStop      = 3'd4,
        StLocked    = 3'd5
    } state_t;

    state_t              r_state;
    logic [TimerW-1:0]   r_timer;
    logic [3:0]          r_tries;
    logic [OccW-1:0]     r_occ;
    logic                r_exit;

    logic                w_full;
    logic                w_waiting;
    logic                w_submit_ok;
    logic                w_submit_bad;
    logic                w_inc;
    logic                w_dec;
    logic                w_expire;
    logic [3:0]          w_tries_nxt;

    assign w_full       = (r_occ == CapVal);
    assign w_waiting    = (r_state == StWaitPass) || (r_state == StWrongPass);
    assign w_submit_ok  = w_waiting && pass_submit && (pass_in == PASSWORD);
    assign w_submit_bad = w_waiting && pass_submit && (pass_in != PASSWORD);
    assign w_inc        = w_submit_ok && !w_full;
    assign w_dec        = exit_sensor && !r_exit && (r_occ != '0);
    // Leaving on the edge where the timer would hit zero gives exactly N cycles in state.
    assign w_expire     = (r_timer <= TimerOne);
    assign w_tries_nxt  = r_tries + 4'd1;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= StIdle;
            r_timer <= '0;
            r_tries <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (entry_sensor && !w_full) begin
                        r_state <= StWaitPass;
                        r_timer <= WaitLd;
                    end
                end
                StWaitPass, StWrongPass: begin
                    if (w_submit_ok) begin
                        r_tries <= '0;
                        if (w_full) begin
                            r_state <= StIdle;
                            r_timer <= '0;
                        end else begin
                            r_state <= StGateOpen;
                            r_timer <= OpenLd;
                        end
                    end else if (w_submit_bad) begin
                        r_tries <= w_tries_nxt;
                        if (w_tries_nxt == MaxTries) begin
                            r_state <= StLocked;
                            r_timer <= LockLd;
                        end else begin
                            r_state <= StWrongPass;
                            r_timer <= WaitLd;
                        end
                    end else if (w_expire) begin
                        r_state <= StIdle;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer - TimerOne;
                    end
                end
                StGateOpen: begin
                    if (w_expire) begin
                        r_state <= entry_sensor ? StStop : StIdle;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer - TimerOne;
                    end
                end
                StStop: begin
                    if (!entry_sensor) begin
                        r_state <= StIdle;
                    end
                end
                StLocked: begin
                    if (w_expire) begin
                        r_state <= StIdle;
                        r_timer <= '0;
                        r_tries <= '0;
                    end else begin
                        r_timer <= r_timer - TimerOne;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // A coincident entry and exit cancel out.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_occ  <= '0;
            r_exit <= 1'b0;
        end else begin
            r_exit <= exit_sensor;
            if (w_inc && !w_dec) begin
                r_occ <= r_occ + OccW'(1);
            end else if (w_dec && !w_inc) begin
                r_occ <= r_occ - OccW'(1);
            end
        end
    end

    assign gate_open  = (r_state == StGateOpen);
    assign alarm      = (r_state == StWrongPass) || (r_state == StStop) || (r_state == StLocked);
    assign lot_full   = w_full;
    assign occupancy  = r_occ;
    assign free_slots = CapVal - r_occ;
    assign state_code = r_state;

endmodule

// File: tb/tb_parking_ctrl_multi.sv
// Bench for parking_ctrl_multi: directed scenarios plus randomized traffic checked
// against a deadline-based behavioural model of the gate and lot.
module tb_parking_ctrl_multi;

    localparam int         CAP   = 8;
    localparam logic [3:0] PW    = 4'b1011;
    localparam int         MAXT  = 3;
    localparam int         WAITC = 500;
    localparam int         OPENC = 200;
    localparam int         LOCKC = 1000;

    localparam int S_IDLE = 0, S_WAIT = 1, S_WRONG = 2, S_OPEN = 3, S_STOP = 4, S_LOCK = 5;

    logic       CLOCK_50 = 1'b0;
    logic       RESET = 1'b1;
    logic       entry_sensor = 1'b0;
    logic       exit_sensor = 1'b0;
    logic [3:0] pass_in = 4'd0;
    logic       pass_submit = 1'b0;
    logic       gate_open, alarm, lot_full;
    logic [3:0] occupancy, free_slots;
    logic [2:0] state_code;

    int n_checks = 0;
    int n_fail = 0;

    // Model: absolute-cycle deadlines instead of a down-counter.
    int cyc = 0;
    int m_st = S_IDLE;
    int m_dl = 0;
    int m_tries = 0;
    int m_occ = 0;
    bit m_xprev = 1'b0;

    parking_ctrl_multi #(
        .CAPACITY   (CAP),
        .PASS_W     (4),
        .PASSWORD   (PW),
        .MAX_TRIES  (MAXT),
        .WAIT_CYCLES(WAITC),
        .OPEN_CYCLES(OPENC),
        .LOCK_CYCLES(LOCKC)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .entry_sensor(entry_sensor),
        .exit_sensor (exit_sensor),
        .pass_in     (pass_in),
        .pass_submit (pass_submit),
        .gate_open   (gate_open),
        .alarm       (alarm),
        .lot_full    (lot_full),
        .occupancy   (occupancy),
        .free_slots  (free_slots),
        .state_code  (state_code)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_st = S_IDLE; m_dl = 0; m_tries = 0; m_occ = 0; m_xprev = 1'b0;
    endtask

    task automatic model_step();
        bit full, inc, dec;
        full = (m_occ == CAP);
        inc = 1'b0;
        cyc++;
        case (m_st)
            S_IDLE: if (entry_sensor && !full) begin m_st = S_WAIT; m_dl = cyc + WAITC; end
            S_WAIT, S_WRONG: begin
                if (pass_submit && pass_in == PW) begin
                    m_tries = 0;
                    if (full) m_st = S_IDLE;
                    else begin m_st = S_OPEN; inc = 1'b1; m_dl = cyc + OPENC; end
                end else if (pass_submit) begin
                    m_tries++;
                    if (m_tries == MAXT) begin m_st = S_LOCK; m_dl = cyc + LOCKC; end
                    else begin m_st = S_WRONG; m_dl = cyc + WAITC; end
                end else if (cyc == m_dl) m_st = S_IDLE;
            end
            S_OPEN: if (cyc == m_dl) m_st = entry_sensor ? S_STOP : S_IDLE;
            S_STOP: if (!entry_sensor) m_st = S_IDLE;
            S_LOCK: if (cyc == m_dl) begin m_st = S_IDLE; m_tries = 0; end
            default: m_st = S_IDLE;
        endcase
        dec = exit_sensor && !m_xprev && (m_occ > 0);
        m_occ = m_occ + int'(inc) - int'(dec);
        m_xprev = exit_sensor;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        entry_sensor = 1'b0; exit_sensor = 1'b0; pass_submit = 1'b0; pass_in = 4'd0;
        RESET = 1'b1;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
    endtask

    task automatic admit_car();
        entry_sensor = 1'b1; tick(); entry_sensor = 1'b0;
        pass_in = PW; pass_submit = 1'b1; tick(); pass_submit = 1'b0; pass_in = 4'd0;
        repeat (OPENC) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (state_code !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_code); end
        n_checks++; if (gate_open !== 1'b0) begin n_fail++; $display("FAIL reset_gate got %b want 0", gate_open); end
        n_checks++; if (alarm !== 1'b0) begin n_fail++; $display("FAIL reset_alarm got %b want 0", alarm); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_checks++; if (free_slots !== 4'(CAP)) begin n_fail++; $display("FAIL reset_free got %0d want %0d", free_slots, CAP); end
        n_checks++; if (lot_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", lot_full); end
    endtask

    task automatic test_entry();
        int cnt;
        do_reset();
        entry_sensor = 1'b1; tick();
        n_checks++; if (state_code !== 3'd1) begin n_fail++; $display("FAIL entry_wait got %0d want 1", state_code); end
        entry_sensor = 1'b0; pass_in = PW; pass_submit = 1'b1; tick(); pass_submit = 1'b0;
        n_checks++; if (state_code !== 3'd3) begin n_fail++; $display("FAIL entry_open got %0d want 3", state_code); end
        n_checks++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL entry_occ got %0d want 1", occupancy); end
        n_checks++; if (free_slots !== 4'd7) begin n_fail++; $display("FAIL entry_free got %0d want 7", free_slots); end
        cnt = 0;
        while (gate_open === 1'b1 && cnt < OPENC + 50) begin cnt++; tick(); end
        n_checks++; if (cnt != OPENC) begin n_fail++; $display("FAIL entry_gate_time got %0d want %0d", cnt, OPENC); end
        n_checks++; if (state_code !== 3'd0) begin n_fail++; $display("FAIL entry_idle got %0d want 0", state_code); end
    endtask

    task automatic test_lockout();
        int cnt;
        do_reset();
        entry_sensor = 1'b1; tick(); entry_sensor = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pass_in = 4'd0; pass_submit = 1'b1; tick(); pass_submit = 1'b0;
            n_checks++; if (state_code !== ((i < 2) ? 3'd2 : 3'd5)) begin
                n_fail++; $display("FAIL lock_try%0d got %0d want %0d", i, state_code, (i < 2) ? 2 : 5); end
            n_checks++; if (alarm !== 1'b1) begin n_fail++; $display("FAIL lock_alarm%0d got %b want 1", i, alarm); end
        end
        cnt = 0;
        while (state_code === 3'd5 && cnt < LOCKC + 50) begin
            cnt++;
            if (cnt == 10) begin pass_in = PW; pass_submit = 1'b1; end
            tick();
            pass_submit = 1'b0;
            if (cnt == 10) begin
                n_checks++; if (state_code !== 3'd5 || occupancy !== 4'd0) begin
                    n_fail++; $display("FAIL lock_ignore state %0d occ %0d want 5/0", state_code, occupancy); end
            end
        end
        n_checks++; if (cnt != LOCKC) begin n_fail++; $display("FAIL lock_time got %0d want %0d", cnt, LOCKC); end
        n_checks++; if (state_code !== 3'd0 || alarm !== 1'b0) begin
            n_fail++; $display("FAIL lock_exit state %0d alarm %b want 0/0", state_code, alarm); end
        // Tries must be cleared: a fresh run of MAX_TRIES wrong submits locks again.
        entry_sensor = 1'b1; tick(); entry_sensor = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pass_in = 4'd6; pass_submit = 1'b1; tick(); pass_submit = 1'b0;
        end
        n_checks++; if (state_code !== 3'd5) begin n_fail++; $display("FAIL lock_relock got %0d want 5", state_code); end
    endtask

    task automatic test_full();
        do_reset();
        repeat (CAP) admit_car();
        n_checks++; if (occupancy !== 4'(CAP) || lot_full !== 1'b1 || free_slots !== 4'd0) begin
            n_fail++; $display("FAIL full_occ occ %0d full %b free %0d want 8/1/0", occupancy, lot_full, free_slots); end
        entry_sensor = 1'b1; repeat (5) tick();
        n_checks++; if (state_code !== 3'd0 || alarm !== 1'b0) begin
            n_fail++; $display("FAIL full_refuse state %0d alarm %b want 0/0", state_code, alarm); end
        entry_sensor = 1'b0; exit_sensor = 1'b1; tick();
        n_checks++; if (occupancy !== 4'd7 || lot_full !== 1'b0 || free_slots !== 4'd1) begin
            n_fail++; $display("FAIL full_exit occ %0d full %b free %0d want 7/0/1", occupancy, lot_full, free_slots); end
        repeat (3) tick();
        n_checks++; if (occupancy !== 4'd7) begin n_fail++; $display("FAIL exit_held got %0d want 7", occupancy); end
        exit_sensor = 1'b0; tick();
    endtask

    task automatic test_simul();
        do_reset();
        repeat (5) admit_car();
        entry_sensor = 1'b1; tick(); entry_sensor = 1'b0;
        pass_in = PW; pass_submit = 1'b1; exit_sensor = 1'b1; tick(); pass_submit = 1'b0;
        n_checks++; if (occupancy !== 4'd5 || state_code !== 3'd3) begin
            n_fail++; $display("FAIL simul occ %0d state %0d want 5/3", occupancy, state_code); end
        exit_sensor = 1'b0;
        repeat (OPENC) tick();
    endtask

    task automatic test_exit_floor();
        do_reset();
        exit_sensor = 1'b1; tick(); exit_sensor = 1'b0; tick();
        n_checks++; if (occupancy !== 4'd0 || free_slots !== 4'(CAP)) begin
            n_fail++; $display("FAIL exit_floor occ %0d free %0d want 0/8", occupancy, free_slots); end
    endtask

    task automatic test_tailgate();
        do_reset();
        entry_sensor = 1'b1; tick();
        pass_in = PW; pass_submit = 1'b1; tick(); pass_submit = 1'b0;
        repeat (OPENC - 1) tick();
        n_checks++; if (state_code !== 3'd3 || gate_open !== 1'b1) begin
            n_fail++; $display("FAIL tail_open state %0d gate %b want 3/1", state_code, gate_open); end
        tick();
        n_checks++; if (state_code !== 3'd4 || alarm !== 1'b1 || gate_open !== 1'b0) begin
            n_fail++; $display("FAIL tail_stop state %0d alarm %b want 4/1", state_code, alarm); end
        entry_sensor = 1'b0; tick();
        n_checks++; if (state_code !== 3'd0 || alarm !== 1'b0) begin
            n_fail++; $display("FAIL tail_idle state %0d alarm %b want 0/0", state_code, alarm); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (2) admit_car();
        entry_sensor = 1'b1; tick(); entry_sensor = 1'b0;
        pass_in = PW; pass_submit = 1'b1; tick(); pass_submit = 1'b0;
        n_checks++; if (occupancy !== 4'd3 || gate_open !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre occ %0d gate %b want 3/1", occupancy, gate_open); end
        repeat (50) tick();
        #5 RESET = 1'b1;
        #1;
        n_checks++; if (gate_open !== 1'b0 || occupancy !== 4'd0 || state_code !== 3'd0) begin
            n_fail++; $display("FAIL mid_reset gate %b occ %0d state %0d want 0/0/0", gate_open, occupancy, state_code); end
        model_reset();
        @(posedge CLOCK_50);
        #1 RESET = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 8000 && n_fail < 40; i++) begin
            entry_sensor = ($urandom_range(0, 1) == 1);
            exit_sensor  = (i < 5000) ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 19) == 0);
            pass_submit  = ($urandom_range(0, 5) == 0);
            pass_in      = ($urandom_range(0, 1) == 1) ? PW : 4'($urandom);
            tick();
            n_checks++; if (state_code !== 3'(m_st)) begin
                n_fail++; $display("FAIL rnd_state cyc %0d got %0d want %0d", i, state_code, m_st); end
            n_checks++; if (occupancy !== 4'(m_occ)) begin
                n_fail++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", i, occupancy, m_occ); end
            n_checks++; if (free_slots !== 4'(CAP - m_occ)) begin
                n_fail++; $display("FAIL rnd_free cyc %0d got %0d want %0d", i, free_slots, CAP - m_occ); end
            n_checks++; if (lot_full !== (m_occ == CAP)) begin
                n_fail++; $display("FAIL rnd_full cyc %0d got %b want %b", i, lot_full, m_occ == CAP); end
            n_checks++; if (gate_open !== (m_st == S_OPEN)) begin
                n_fail++; $display("FAIL rnd_gate cyc %0d got %b want %b", i, gate_open, m_st == S_OPEN); end
            n_checks++; if (alarm !== (m_st == S_WRONG || m_st == S_STOP || m_st == S_LOCK)) begin
                n_fail++; $display("FAIL rnd_alarm cyc %0d got %b state %0d", i, alarm, m_st); end
        end
        pass_submit = 1'b0; entry_sensor = 1'b0; exit_sensor = 1'b0;
    endtask

    initial begin
        test_reset();
        test_entry();
        test_lockout();
        test_full();
        test_simul();
        test_exit_floor();
        test_tailgate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
